// File: rtl/add_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add_arbiter_pkg                                                      |
// | Shared widths, arbiter defaults and the arbiter state encoding.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package add_arbiter_pkg;

  localparam int DATA_WIDTH  = 448;
  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add_arbiter_if                                                       |
// | Requester-side bundle: request levels, operands, grant/completion.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface add_arbiter_if
  import add_arbiter_pkg::*;
#(
  parameter int SIZE    = DATA_WIDTH,
  parameter int NUM_REQ = ARB_NUM_REQ
) ();

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0][SIZE-1:0] a_in;
  logic [NUM_REQ-1:0][SIZE-1:0] b_in;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           done_o;
  logic [NUM_REQ-1:0]           err_o;
  logic [SIZE:0]                result_o;
  logic                         busy;

  modport master (
    output req, a_in, b_in,
    input  gnt, done_o, err_o, result_o, busy
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, done_o, err_o, result_o, busy
  );

endinterface
`default_nettype wire

// File: rtl/add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add                                                                  |
// | Multi-cycle wide adder with start/done handshake.                    |
// | done pulses LATENCY+1 cycles after the start cycle.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module add
  import add_arbiter_pkg::*;
#(
  parameter int SIZE    = DATA_WIDTH,
  parameter int LATENCY = 3
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            start,
  input  wire logic [SIZE-1:0] a,
  input  wire logic [SIZE-1:0] b,
  output logic      [SIZE:0]   result,
  output logic                 done
);

  logic [SIZE:0] r_sum;
  logic [7:0]    r_cnt;
  logic          r_done;

  // Latch the sum on start, count down the latency, then pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_sum <= {1'b0, a} + {1'b0, b};
        r_cnt <= 8'(LATENCY);
      end else if (r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
        if (r_cnt == 8'd1) r_done <= 1'b1;
      end
    end
  end

  assign result = r_sum;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick                                                              |
// | Combinational round-robin selector; search starts after i_last.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick
  import add_arbiter_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int IDX_W   = idx_width(ARB_NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] i_req,
  input  wire logic [IDX_W-1:0]   i_last,
  output logic      [NUM_REQ-1:0] o_gnt,
  output logic      [IDX_W-1:0]   o_idx,
  output logic                    o_valid
);

  logic [IDX_W-1:0] w_cand;

  // Walk last+1 .. last+NUM_REQ (mod NUM_REQ); first active request wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(i_last) + i) % NUM_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add_arbiter                                                          |
// | Round-robin sharing of one wide adder between NUM_REQ requesters,    |
// | with a watchdog that turns a missing done into an error completion. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int SIZE    = DATA_WIDTH,
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input wire logic    clk,
  input wire logic    rst,   // active-low, asynchronous assert
  add_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_owner;
  logic [SIZE-1:0]    r_op_a;
  logic [SIZE-1:0]    r_op_b;
  logic [SIZE:0]      r_result;
  logic               r_err;
  logic [WD_W-1:0]    r_wd;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_valid;
  logic [NUM_REQ-1:0] w_gnt;
  logic [NUM_REQ-1:0] w_done;
  logic [NUM_REQ-1:0] w_errv;
  logic               w_start;
  logic               w_add_done;
  logic [SIZE:0]      w_add_result;
  logic               w_add_rst;
  logic               w_wd_expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (bus.req),
    .i_last  (r_last),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_add_rst = ~rst;

  add #(
    .SIZE (SIZE)
  ) u_add (
    .clk    (clk),
    .rst    (w_add_rst),
    .start  (w_start),
    .a      (r_op_a),
    .b      (r_op_b),
    .result (w_add_result),
    .done   (w_add_done)
  );

  assign w_wd_expired = (r_wd == WD_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_gnt   = '0;
    w_done  = '0;
    w_errv  = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_gnt  = w_pick_gnt;
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        w_start = 1'b1;
        w_next  = WAIT;
      end
      WAIT: begin
        if (w_add_done || w_wd_expired) w_next = RESP;
      end
      RESP: begin
        w_done[r_owner] = 1'b1;
        if (r_err) w_errv[r_owner] = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand/owner capture, watchdog, result and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last   <= IDX_W'(NUM_REQ - 1);
      r_owner  <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_wd     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_op_a  <= bus.a_in[w_pick_idx];
            r_op_b  <= bus.b_in[w_pick_idx];
            r_owner <= w_pick_idx;
            r_last  <= w_pick_idx;
          end
        end
        ISSUE: r_wd <= '0;
        WAIT: begin
          // A done arriving on the expiry cycle still counts as success.
          if (w_add_done)        r_result <= w_add_result;
          else if (w_wd_expired) r_err    <= 1'b1;
          else                   r_wd     <= r_wd + WD_W'(1);
        end
        RESP: r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  // Grants are suppressed while reset is held so nothing leaks out.
  assign bus.gnt      = rst ? w_gnt : '0;
  assign bus.done_o   = w_done;
  assign bus.err_o    = w_errv;
  assign bus.result_o = r_result;
  assign bus.busy     = (r_state != IDLE);

endmodule
`default_nettype wire
